// File: rtl/rvsteel_board_inputs.sv
// -----------------------------------------------------------------------------
// rvsteel_board_inputs
//   Board-side conditioner for the SoC reset and halt push-buttons. Each raw
//   pin is optionally inverted, passed through a 2-flop synchroniser and
//   debounced. A small reset FSM stretches soc_reset to a minimum width after
//   the reset source releases, and soc_halt is masked while the SoC is held in
//   reset. Both outputs come straight from flops.
//
//   Ports:
//     clock         in   system clock (shared with the SoC)
//     reset_n       in   asynchronous active-low board/power-on reset
//     reset_button  in   raw, asynchronous, bouncing reset button
//     halt_button   in   raw, asynchronous, bouncing halt button
//     soc_reset     out  active-high conditioned reset for the wrapper
//     soc_halt      out  active-high conditioned halt for the wrapper
//
//   Build option:
//     RVSTEEL_BOARD_INPUTS_HALT_TOGGLE_EN
//       defined   : each accepted press of the halt button (in RUN) toggles
//                   a halt latch; soc_halt follows the latch.
//       undefined : soc_halt follows the debounced halt level.
//
//   Reset FSM states:
//     state     | meaning
//     ----------+-----------------------------------------------------------
//     ST_ACTIVE | reset source asserted; soc_reset held high
//     ST_HOLD   | source released; counting the minimum hold period
//     ST_RUN    | SoC running; soc_reset low, soc_halt enabled
// -----------------------------------------------------------------------------
module rvsteel_board_inputs #(
  parameter int DEBOUNCE_CYCLES   = 1000000,
  parameter int RESET_HOLD_CYCLES = 16,
  parameter bit BUTTON_ACTIVE_LOW = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic reset_button,
  input  logic halt_button,
  output logic soc_reset,
  output logic soc_halt
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

  // Bit 0 carries the reset button, bit 1 the halt button.
  localparam int IDX_RESET = 0;
  localparam int IDX_HALT  = 1;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_HOLD   = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  logic [1:0]      raw;
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      db;
  logic [DB_W-1:0] db_cnt [2];

  logic db_reset;
  logic db_halt;

  state_t            state;
  state_t            state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;
  logic              halt_src;

  // Inversion happens before the synchronisers so that everything downstream
  // (including the reset value of the sync flops) is in active-high terms.
  assign raw = BUTTON_ACTIVE_LOW ? ~{halt_button, reset_button}
                                 :  {halt_button, reset_button};

  // Synchroniser and debounce. The counter only runs while the synchronised
  // input disagrees with the accepted level; any agreement restarts it, so a
  // bounce shorter than DEBOUNCE_CYCLES never gets accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign db_reset = db[IDX_RESET];
  assign db_halt  = db[IDX_HALT];

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    case (state)
      ST_ACTIVE: begin
        if (!db_reset) begin
          state_nxt = ST_HOLD;
          hold_nxt  = '0;
        end
      end
      ST_HOLD: begin
        if (db_reset) begin
          state_nxt = ST_ACTIVE;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = ST_RUN;
        end else begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        if (db_reset) begin
          state_nxt = ST_ACTIVE;
        end
      end
      default: begin
        state_nxt = ST_ACTIVE;
      end
    endcase
  end

`ifdef RVSTEEL_BOARD_INPUTS_HALT_TOGGLE_EN
  logic db_halt_q;
  logic halt_latch;
  logic halt_latch_nxt;

  // Only a press seen while staying in RUN toggles the latch; a press that
  // lands together with a reset request is dropped because reset wins.
  always_comb begin
    halt_latch_nxt = halt_latch;
    if (state == ST_ACTIVE || state_nxt == ST_ACTIVE) begin
      halt_latch_nxt = 1'b0;
    end else if (state == ST_RUN && state_nxt == ST_RUN && db_halt && !db_halt_q) begin
      halt_latch_nxt = ~halt_latch;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      db_halt_q  <= 1'b0;
      halt_latch <= 1'b0;
    end else begin
      db_halt_q  <= db_halt;
      halt_latch <= halt_latch_nxt;
    end
  end

  assign halt_src = halt_latch_nxt;
`else
  assign halt_src = db_halt;
`endif

  // Outputs are registered from the next-state values so they change on the
  // same edge as the state and never glitch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_ACTIVE;
      hold_cnt  <= '0;
      soc_reset <= 1'b1;
      soc_halt  <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_cnt  <= hold_nxt;
      soc_reset <= (state_nxt != ST_RUN);
      soc_halt  <= (state_nxt == ST_RUN) && halt_src;
    end
  end

endmodule

// File: tb/tb_rvsteel_board_inputs.sv
// -----------------------------------------------------------------------------
// tb_rvsteel_board_inputs
//   Directed bench for rvsteel_board_inputs with DEBOUNCE_CYCLES=8,
//   RESET_HOLD_CYCLES=4. Pin-to-debounced latency is 10 edges, so a reset
//   request shows on soc_reset at edge 11 and a release at edge 15.
//   Inputs are driven 1 time unit after a rising edge and outputs sampled at
//   the same point, so "edge k" below means the k-th rising edge after the
//   pin change.
// -----------------------------------------------------------------------------
module tb_rvsteel_board_inputs;

  logic clock;
  logic reset_n;
  logic reset_button;
  logic halt_button;
  logic soc_reset;
  logic soc_halt;

  int tests_run;
  int tests_failed;

`ifdef RVSTEEL_BOARD_INPUTS_HALT_TOGGLE_EN
  localparam bit TOGGLE = 1'b1;
`else
  localparam bit TOGGLE = 1'b0;
`endif

  rvsteel_board_inputs #(
    .DEBOUNCE_CYCLES  (8),
    .RESET_HOLD_CYCLES(4),
    .BUTTON_ACTIVE_LOW(1'b0)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .reset_button(reset_button),
    .halt_button (halt_button),
    .soc_reset   (soc_reset),
    .soc_halt    (soc_halt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Board reset pulse followed by the hold period, leaving the FSM in RUN.
  task automatic do_por();
    reset_n = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(6);
  endtask

  task automatic test_reset();
    logic exp;
    reset_button = 1'b0;
    halt_button  = 1'b0;
    #2 reset_n = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      tests_run++;
      if (soc_reset !== 1'b1) begin
        tests_failed++;
        $display("FAIL reset_in_por: soc_reset=%b expected 1 (cycle %0d)", soc_reset, k);
      end
      tests_run++;
      if (soc_halt !== 1'b0) begin
        tests_failed++;
        $display("FAIL halt_in_por: soc_halt=%b expected 0 (cycle %0d)", soc_halt, k);
      end
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      exp = (k < 5);
      tests_run++;
      if (soc_reset !== exp) begin
        tests_failed++;
        $display("FAIL reset_release: soc_reset=%b expected %b (edge %0d)", soc_reset, exp, k);
      end
    end
  endtask

  task automatic test_reset_bounce();
    logic exp;
    for (int i = 0; i < 10; i++) begin
      reset_button = (i % 2 == 0);
      for (int j = 0; j < 3; j++) begin
        tick(1);
        tests_run++;
        if (soc_reset !== 1'b0) begin
          tests_failed++;
          $display("FAIL reset_bounce: soc_reset=%b expected 0 (toggle %0d)", soc_reset, i);
        end
      end
    end
    reset_button = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick(1);
      exp = (k >= 11);
      tests_run++;
      if (soc_reset !== exp) begin
        tests_failed++;
        $display("FAIL reset_press: soc_reset=%b expected %b (edge %0d)", soc_reset, exp, k);
      end
    end
  endtask

  task automatic test_reset_release();
    logic exp;
    // Short release then re-press: the release is never accepted.
    reset_button = 1'b0;
    tick(5);
    reset_button = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      tests_run++;
      if (soc_reset !== 1'b1) begin
        tests_failed++;
        $display("FAIL reset_repress: soc_reset=%b expected 1 (edge %0d)", soc_reset, k);
      end
    end
    reset_button = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      exp = (k < 15);
      tests_run++;
      if (soc_reset !== exp) begin
        tests_failed++;
        $display("FAIL reset_button_release: soc_reset=%b expected %b (edge %0d)", soc_reset, exp, k);
      end
    end
  endtask

  task automatic test_halt();
    logic exp;
    halt_button = 1'b1;
    tick(7);
    halt_button = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      tests_run++;
      if (soc_halt !== 1'b0) begin
        tests_failed++;
        $display("FAIL halt_short_pulse: soc_halt=%b expected 0 (edge %0d)", soc_halt, k);
      end
    end
    halt_button = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      exp = (k >= 11);
      tests_run++;
      if (soc_halt !== exp) begin
        tests_failed++;
        $display("FAIL halt_hold: soc_halt=%b expected %b (edge %0d)", soc_halt, exp, k);
      end
    end
    halt_button = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      exp = TOGGLE ? 1'b1 : (k < 11);
      tests_run++;
      if (soc_halt !== exp) begin
        tests_failed++;
        $display("FAIL halt_release: soc_halt=%b expected %b (edge %0d)", soc_halt, exp, k);
      end
    end
  endtask

  task automatic test_halt_sequence();
    logic exp;
    logic exp_r;
    do_por();
    for (int phase = 0; phase < 5; phase++) begin
      halt_button = (phase % 2 == 0);
      for (int k = 1; k <= 12; k++) begin
        tick(1);
        case (phase)
          0:       exp = (k >= 11);
          1:       exp = TOGGLE ? 1'b1 : (k < 11);
          2:       exp = TOGGLE ? (k < 11) : (k >= 11);
          3:       exp = TOGGLE ? 1'b0 : (k < 11);
          default: exp = (k >= 11);
        endcase
        tests_run++;
        if (soc_halt !== exp) begin
          tests_failed++;
          $display("FAIL halt_seq: soc_halt=%b expected %b (phase %0d edge %0d)", soc_halt, exp, phase, k);
        end
      end
    end
    // Halted; a reset press must drop soc_halt together with raising soc_reset.
    reset_button = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick(1);
      exp   = (k < 11);
      exp_r = (k >= 11);
      tests_run++;
      if (soc_halt !== exp || soc_reset !== exp_r) begin
        tests_failed++;
        $display("FAIL reset_clears_halt: halt=%b reset=%b expected halt=%b reset=%b (edge %0d)",
                 soc_halt, soc_reset, exp, exp_r, k);
      end
    end
    reset_button = 1'b0;
    halt_button  = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      exp_r = (k < 15);
      tests_run++;
      if (soc_halt !== 1'b0 || soc_reset !== exp_r) begin
        tests_failed++;
        $display("FAIL halt_after_reset: halt=%b reset=%b expected halt=0 reset=%b (edge %0d)",
                 soc_halt, soc_reset, exp_r, k);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic exp_r;
    reset_button = 1'b1;
    halt_button  = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      exp_r = (k >= 11);
      tests_run++;
      if (soc_halt !== 1'b0 || soc_reset !== exp_r) begin
        tests_failed++;
        $display("FAIL simultaneous_press: halt=%b reset=%b expected halt=0 reset=%b (edge %0d)",
                 soc_halt, soc_reset, exp_r, k);
      end
    end
    reset_button = 1'b0;
    halt_button  = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick(1);
      exp_r = (k < 15);
      tests_run++;
      if (soc_halt !== 1'b0 || soc_reset !== exp_r) begin
        tests_failed++;
        $display("FAIL simultaneous_release: halt=%b reset=%b expected halt=0 reset=%b (edge %0d)",
                 soc_halt, soc_reset, exp_r, k);
      end
    end
  endtask

  task automatic test_reset_midcount();
    logic exp;
    logic exp_r;
    halt_button = 1'b1;
    tick(7);
    tests_run++;
    if (soc_reset !== 1'b0) begin
      tests_failed++;
      $display("FAIL midcount_pre: soc_reset=%b expected 0", soc_reset);
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (soc_reset !== 1'b1 || soc_halt !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: reset=%b halt=%b expected reset=1 halt=0", soc_reset, soc_halt);
    end
    tick(2);
    reset_n = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick(1);
      exp   = (k >= 11);
      exp_r = (k < 5);
      tests_run++;
      if (soc_halt !== exp || soc_reset !== exp_r) begin
        tests_failed++;
        $display("FAIL halt_recount: halt=%b reset=%b expected halt=%b reset=%b (edge %0d)",
                 soc_halt, soc_reset, exp, exp_r, k);
      end
    end
    halt_button = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b1;
    reset_button = 1'b0;
    halt_button  = 1'b0;
    test_reset();
    test_reset_bounce();
    test_reset_release();
    test_halt();
    test_halt_sequence();
    test_simultaneous();
    test_reset_midcount();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
